// File: rtl/adder_pkg.sv
// Shared constants for the operand loader and the downstream adder tree.
package adder_pkg;
    localparam int DATA_W  = 4;
    localparam int NUM_OPS = 8;
    localparam int SUM_W   = 15;
endpackage

// File: rtl/operand_loader_if.sv
// Serial-in / parallel-out handshake bundle of the operand loader.
interface operand_loader_if #(parameter int DATA_W = adder_pkg::DATA_W);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [DATA_W-1:0] p0, p1, p2, p3, p4, p5, p6, p7;
    logic              out_valid;
    logic              out_ready;

    // master: beat producer and frame consumer; slave: the loader
    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, p0, p1, p2, p3, p4, p5, p6, p7, out_valid
    );
    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, p0, p1, p2, p3, p4, p5, p6, p7, out_valid
    );
endinterface

// File: rtl/operand_bank.sv
// One frame of operand storage, written one nibble at a time by index.
module operand_bank #(
    parameter int DATA_W  = adder_pkg::DATA_W,
    parameter int NUM_OPS = adder_pkg::NUM_OPS,
    parameter int IDX_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_idx,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [NUM_OPS-1:0][DATA_W-1:0]   ops
);
    logic [NUM_OPS-1:0][DATA_W-1:0] ops_q, ops_d;

    always_comb begin
        ops_d = ops_q;
        if (wr_en) ops_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) ops_q <= '0;
        else     ops_q <= ops_d;
    end

    assign ops = ops_q;
endmodule

// File: rtl/operand_loader.sv
// Ping-pong frame loader: serial nibbles fill one bank while the other is
// presented in parallel to the adder tree.
module operand_loader #(
    parameter int DATA_W  = adder_pkg::DATA_W,
    parameter int NUM_OPS = adder_pkg::NUM_OPS
) (
    input  logic             clk,
    input  logic             rst,
    operand_loader_if.slave  bus
);
    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;

    logic       in_ready, accept, last, drain;
    logic [1:0] bank_we;
    logic [NUM_OPS-1:0][DATA_W-1:0] bank_ops [2];
    logic [NUM_OPS-1:0][DATA_W-1:0] rd_ops;

    // in_ready depends only on flops, so out_ready never reaches it combinationally
    assign in_ready = ~full_q[wr_bank_q];
    assign accept   = bus.in_valid & in_ready & ~bus.flush;
    assign last     = accept && (wr_idx_q == IDX_W'(NUM_OPS - 1));
    assign drain    = full_q[rd_bank_q] & bus.out_ready;

    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        bank_we   = '0;
        bank_we[wr_bank_q] = accept;
        if (bus.flush)   wr_idx_d = '0;
        else if (accept) wr_idx_d = last ? '0 : wr_idx_q + 1'b1;
        // completion targets an empty bank, drain a full one: never the same bank
        if (last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (drain) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        operand_bank #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .IDX_W(IDX_W)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (bank_we[b]),
            .wr_idx  (wr_idx_q),
            .wr_data (bus.in_data),
            .ops     (bank_ops[b])
        );
    end

    assign rd_ops        = bank_ops[rd_bank_q];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = full_q[rd_bank_q];
    assign bus.p0 = rd_ops[0];
    assign bus.p1 = rd_ops[1];
    assign bus.p2 = rd_ops[2];
    assign bus.p3 = rd_ops[3];
    assign bus.p4 = rd_ops[4];
    assign bus.p5 = rd_ops[5];
    assign bus.p6 = rd_ops[6];
    assign bus.p7 = rd_ops[7];
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: handshake, ping-pong, flush and reset cases.
module tb_operand_loader;
    typedef logic [7:0][3:0] frame_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    operand_loader_if #(.DATA_W(4)) ifc ();
    operand_loader #(.DATA_W(4), .NUM_OPS(8)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    frame_t pv;
    assign pv = {ifc.p7, ifc.p6, ifc.p5, ifc.p4, ifc.p3, ifc.p2, ifc.p1, ifc.p0};

    // handshake inputs only change at posedge+1, so a negedge look predicts the next edge
    frame_t got_q[$];
    always @(negedge clk)
        if (!rst && ifc.out_valid && ifc.out_ready) got_q.push_back(pv);

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] d);
        ifc.in_data = d; ifc.in_valid = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.flush = 1'b0; ifc.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", ifc.out_valid); end
        tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", ifc.in_ready); end
        tests++; if (pv !== '0) begin fails++; $display("FAIL reset_ops: got %h exp 0", pv); end
    endtask

    task automatic test_basic();
        frame_t e;
        int stalls = 0;
        got_q.delete();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e[i] = 4'(i + 1);
            if (ifc.in_ready !== 1'b1) stalls++;
            send(4'(i + 1));
        end
        ifc.in_valid = 1'b0;
        tests++; if (stalls != 0) begin fails++; $display("FAIL basic_in_ready: got %0d stalls exp 0", stalls); end
        tests++; if (ifc.out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: got %b exp 1", ifc.out_valid); end
        tests++; if (pv !== e) begin fails++; $display("FAIL basic_ops: got %h exp %h", pv, e); end
        tick();
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle: got %b exp 0", ifc.out_valid); end
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL basic_count: got %0d exp 1", got_q.size()); end
    endtask

    task automatic test_backpressure();
        frame_t ef = {8{4'hF}};
        frame_t e3 = {8{4'h3}};
        int stalls = 0;
        got_q.delete();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ifc.in_ready !== 1'b1) stalls++;
            send(i < 8 ? 4'hF : 4'h3);
        end
        tests++; if (stalls != 0) begin fails++; $display("FAIL bp_fill_ready: got %0d stalls exp 0", stalls); end
        tests++; if (ifc.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full: got %b exp 0", ifc.in_ready); end
        ifc.in_data = 4'h5;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (ifc.out_valid !== 1'b1 || pv !== ef) begin fails++; $display("FAIL bp_hold: got v=%b %h exp v=1 %h", ifc.out_valid, pv, ef); end
        end
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        tick();
        tests++; if (ifc.out_valid !== 1'b1 || pv !== e3) begin fails++; $display("FAIL bp_second: got v=%b %h exp v=1 %h", ifc.out_valid, pv, e3); end
        tick();
        tests++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin fails++; $display("FAIL bp_empty: got v=%b r=%b exp v=0 r=1", ifc.out_valid, ifc.in_ready); end
        tests++; if (got_q.size() != 2 || got_q[0] !== ef || got_q[1] !== e3) begin fails++; $display("FAIL bp_order: got n=%0d exp n=2 F then 3", got_q.size()); end
    endtask

    task automatic test_flush();
        frame_t e;
        got_q.delete();
        ifc.out_ready = 1'b1;
        send(4'hA); send(4'hB); send(4'hC);
        ifc.flush = 1'b1; ifc.in_data = 4'hD;
        tests++; if (ifc.in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b exp 1", ifc.in_ready); end
        tick();
        ifc.flush = 1'b0;
        for (int i = 0; i < 8; i++) begin e[i] = 4'(i + 1); send(4'(i + 1)); end
        ifc.in_valid = 1'b0;
        tick();
        tests++; if (got_q.size() != 1 || got_q[0] !== e) begin fails++; $display("FAIL flush_frame: got n=%0d %h exp n=1 %h", got_q.size(), got_q.size() ? got_q[0] : '0, e); end
    endtask

    task automatic test_flush_last();
        frame_t e;
        got_q.delete();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(4'h9);
        ifc.flush = 1'b1;
        send(4'h9);
        ifc.flush = 1'b0; ifc.in_valid = 1'b0;
        tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL flushlast_no_valid: got %b exp 0", ifc.out_valid); end
        for (int i = 0; i < 8; i++) begin e[i] = 4'(8 - i); send(4'(8 - i)); end
        ifc.in_valid = 1'b0;
        tick();
        tests++; if (got_q.size() != 1 || got_q[0] !== e) begin fails++; $display("FAIL flushlast_frame: got n=%0d %h exp n=1 %h", got_q.size(), got_q.size() ? got_q[0] : '0, e); end
    endtask

    task automatic test_reset_mid();
        frame_t e6 = {8{4'h6}};
        frame_t e;
        got_q.delete();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(4'h6);
        for (int i = 0; i < 5; i++) send(4'h7);
        tests++; if (ifc.out_valid !== 1'b1 || pv !== e6) begin fails++; $display("FAIL rstmid_pending: got v=%b %h exp v=1 %h", ifc.out_valid, pv, e6); end
        rst = 1'b1; ifc.in_data = 4'hE;
        tick();
        rst = 1'b0; ifc.in_valid = 1'b0;
        tests++; if (ifc.out_valid !== 1'b0 || pv !== '0 || ifc.in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_clear: got v=%b r=%b %h exp v=0 r=1 0", ifc.out_valid, ifc.in_ready, pv); end
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin e[i] = 4'(i + 1); send(4'(i + 1)); end
        ifc.in_valid = 1'b0;
        tick();
        tests++; if (got_q.size() != 1 || got_q[0] !== e) begin fails++; $display("FAIL rstmid_next: got n=%0d %h exp n=1 %h", got_q.size(), got_q.size() ? got_q[0] : '0, e); end
    endtask

    task automatic test_random();
        frame_t exp_q[$];
        frame_t e;
        int stalls = 0;
        int bad = 0;
        got_q.delete();
        ifc.out_ready = 1'b1;
        for (int f = 0; f < 64; f++) begin
            for (int i = 0; i < 8; i++) begin
                e[i] = 4'($urandom_range(0, 15));
                if (ifc.in_ready !== 1'b1) stalls++;
                send(e[i]);
            end
            exp_q.push_back(e);
        end
        ifc.in_valid = 1'b0;
        tick(); tick();
        tests++; if (stalls != 0) begin fails++; $display("FAIL rand_in_ready: got %0d stalls exp 0", stalls); end
        tests++; if (got_q.size() != 64) begin fails++; $display("FAIL rand_count: got %0d exp 64", got_q.size()); end
        for (int f = 0; f < 64 && f < got_q.size(); f++)
            if (got_q[f] !== exp_q[f]) begin
                bad++;
                if (bad < 4) $display("FAIL rand_frame %0d: got %h exp %h", f, got_q[f], exp_q[f]);
            end
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_frames: got %0d bad frames exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_flush_last();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
